// File: rtl/clockmaster_pkg.sv
// Shared clockmaster definitions: write-target id map and the demux FSM state encoding.
package clockmaster_pkg;

    localparam int unsigned TGT_MAIN_MEMORY      = 0;
    localparam int unsigned TGT_PPS_DIV_BASE     = 1;
    localparam int unsigned DEFAULT_N_PPS_DIV    = 4;
    localparam int unsigned TGT_PULSE_GEN_BASE   = 1 + DEFAULT_N_PPS_DIV;

    // Pulse generators follow the pps dividers, so their base moves with the divider count.
    function automatic int unsigned pulse_gen_base(input int unsigned n_pps_div);
        return TGT_PPS_DIV_BASE + n_pps_div;
    endfunction

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StHeader  = 2'd1;
    localparam logic [1:0] StData    = 2'd2;
    localparam logic [1:0] StDiscard = 2'd3;

endpackage

// File: rtl/demux_data_write_decode.sv
// Header target decode: maps a 4-bit target id onto one-hot selects plus a valid flag.
module demux_target_decode
    import clockmaster_pkg::*;
#(
    parameter int unsigned N_PPS_DIV   = 4,
    parameter int unsigned N_PULSE_GEN = 4
) (
    input  logic [3:0]             id_i,
    output logic                   sel_main_o,
    output logic [N_PPS_DIV-1:0]   sel_pps_div_o,
    output logic [N_PULSE_GEN-1:0] sel_pulse_gen_o,
    output logic                   valid_o
);

    logic [31:0] id_ext;
    assign id_ext = 32'(id_i);

    always_comb begin
        sel_main_o      = 1'b0;
        sel_pps_div_o   = '0;
        sel_pulse_gen_o = '0;
        if (id_ext == TGT_MAIN_MEMORY) begin
            sel_main_o = 1'b1;
        end
        for (int unsigned i = 0; i < N_PPS_DIV; i++) begin
            if (id_ext == TGT_PPS_DIV_BASE + i) begin
                sel_pps_div_o[i] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N_PULSE_GEN; i++) begin
            if (id_ext == pulse_gen_base(N_PPS_DIV) + i) begin
                sel_pulse_gen_o[i] = 1'b1;
            end
        end
    end

    assign valid_o = sel_main_o | (|sel_pps_div_o) | (|sel_pulse_gen_o);

endmodule

// File: rtl/demux_data_write.sv
// Host write demultiplexer: a header byte picks a target and start address, then each data
// byte is presented with a one-cycle write strobe and an auto-incrementing register address.
module demux_data_write
    import clockmaster_pkg::*;
#(
    parameter int unsigned N_PPS_DIV   = 4,
    parameter int unsigned N_PULSE_GEN = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_frame,
    input  logic                   i_rx_valid,
    input  logic [7:0]             i_rx_data,
    output logic [7:0]             o_data,
    output logic [3:0]             o_reg_addr,
    output logic [N_PPS_DIV-1:0]   o_wr_pps_div,
    output logic [N_PULSE_GEN-1:0] o_wr_pulse_gen,
    output logic                   o_wr_main_memory,
    output logic                   o_err
);

    logic [1:0]             state_q, state_d;
    logic [3:0]             addr_q, addr_d;
    logic                   sel_main_q, sel_main_d;
    logic [N_PPS_DIV-1:0]   sel_pps_q, sel_pps_d;
    logic [N_PULSE_GEN-1:0] sel_pg_q, sel_pg_d;
    logic [7:0]             data_q, data_d;
    logic [3:0]             reg_addr_q, reg_addr_d;
    logic                   wr_main_q, wr_main_d;
    logic [N_PPS_DIV-1:0]   wr_pps_q, wr_pps_d;
    logic [N_PULSE_GEN-1:0] wr_pg_q, wr_pg_d;
    logic                   err_q, err_d;
    logic                   frame_q;
    logic                   frame_rise;

    logic                   dec_main;
    logic [N_PPS_DIV-1:0]   dec_pps;
    logic [N_PULSE_GEN-1:0] dec_pg;
    logic                   dec_valid;

    demux_target_decode #(
        .N_PPS_DIV   (N_PPS_DIV),
        .N_PULSE_GEN (N_PULSE_GEN)
    ) u_decode (
        .id_i            (i_rx_data[7:4]),
        .sel_main_o      (dec_main),
        .sel_pps_div_o   (dec_pps),
        .sel_pulse_gen_o (dec_pg),
        .valid_o         (dec_valid)
    );

    // A frame still open across reset must not restart; only a true low-to-high edge does.
    assign frame_rise = i_frame & ~frame_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        sel_main_d = sel_main_q;
        sel_pps_d  = sel_pps_q;
        sel_pg_d   = sel_pg_q;
        data_d     = data_q;
        reg_addr_d = reg_addr_q;
        wr_main_d  = 1'b0;
        wr_pps_d   = '0;
        wr_pg_d    = '0;
        err_d      = err_q;
        case (state_q)
            StIdle: begin
                if (frame_rise) begin
                    state_d = StHeader;
                    err_d   = 1'b0;
                end
            end
            StHeader: begin
                if (!i_frame) begin
                    state_d = StIdle;
                end else if (i_rx_valid) begin
                    addr_d     = i_rx_data[3:0];
                    sel_main_d = dec_main;
                    sel_pps_d  = dec_pps;
                    sel_pg_d   = dec_pg;
                    if (dec_valid) begin
                        state_d = StData;
                    end else begin
                        state_d = StDiscard;
                        err_d   = 1'b1;
                    end
                end
            end
            StData: begin
                if (!i_frame) begin
                    state_d = StIdle;
                end else if (i_rx_valid) begin
                    data_d     = i_rx_data;
                    reg_addr_d = addr_q;
                    wr_main_d  = sel_main_q;
                    wr_pps_d   = sel_pps_q;
                    wr_pg_d    = sel_pg_q;
                    addr_d     = addr_q + 4'd1;
                end
            end
            StDiscard: begin
                if (!i_frame) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        frame_q <= i_frame;
        if (i_rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            sel_main_q <= 1'b0;
            sel_pps_q  <= '0;
            sel_pg_q   <= '0;
            data_q     <= '0;
            reg_addr_q <= '0;
            wr_main_q  <= 1'b0;
            wr_pps_q   <= '0;
            wr_pg_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            sel_main_q <= sel_main_d;
            sel_pps_q  <= sel_pps_d;
            sel_pg_q   <= sel_pg_d;
            data_q     <= data_d;
            reg_addr_q <= reg_addr_d;
            wr_main_q  <= wr_main_d;
            wr_pps_q   <= wr_pps_d;
            wr_pg_q    <= wr_pg_d;
            err_q      <= err_d;
        end
    end

    assign o_data           = data_q;
    assign o_reg_addr       = reg_addr_q;
    assign o_wr_pps_div     = wr_pps_q;
    assign o_wr_pulse_gen   = wr_pg_q;
    assign o_wr_main_memory = wr_main_q;
    assign o_err            = err_q;

endmodule

// File: tb/tb_demux_data_write.sv
// Directed bench for demux_data_write: per-cycle vector table plus hand-written corner sequences.
module tb_demux_data_write;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] data;
    logic [3:0] reg_addr;
    logic [3:0] wr_pps;
    logic [3:0] wr_pg;
    logic       wr_mm;
    logic       err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    demux_data_write #(
        .N_PPS_DIV   (4),
        .N_PULSE_GEN (4)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_frame          (frame),
        .i_rx_valid       (rx_valid),
        .i_rx_data        (rx_data),
        .o_data           (data),
        .o_reg_addr       (reg_addr),
        .o_wr_pps_div     (wr_pps),
        .o_wr_pulse_gen   (wr_pg),
        .o_wr_main_memory (wr_mm),
        .o_err            (err)
    );

    typedef struct {
        logic       f;
        logic       v;
        logic [7:0] d;
        logic [7:0] ed;
        logic [3:0] ea;
        logic [3:0] epps;
        logic [3:0] epg;
        logic       em;
        logic       ee;
    } vec_t;

    vec_t vecs[$];

    // Drive inputs, then sample 1 time unit after the next rising edge.
    task automatic apply(input logic f, input logic v, input logic [7:0] d);
        frame    = f;
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] ed, input logic [3:0] ea,
                         input logic [3:0] epps, input logic [3:0] epg, input logic em,
                         input logic ee);
        logic [21:0] got;
        logic [21:0] exp;
        got = {data, reg_addr, wr_pps, wr_pg, wr_mm, err};
        exp = {ed, ea, epps, epg, em, ee};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got data=%h addr=%h pps=%b pg=%b mm=%b err=%b, want data=%h addr=%h pps=%b pg=%b mm=%b err=%b",
                     name, data, reg_addr, wr_pps, wr_pg, wr_mm, err, ed, ea, epps, epg, em, ee);
        end
    endtask

    initial begin
        rst = 1'b1; frame = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        // Header 0x23 -> pps_div[1], addresses 3,4.
        vecs.push_back('{1, 0, 8'h00, 8'h00, 4'h0, 4'b0000, 4'b0000, 0, 0});
        vecs.push_back('{1, 1, 8'h23, 8'h00, 4'h0, 4'b0000, 4'b0000, 0, 0});
        vecs.push_back('{1, 1, 8'hAA, 8'hAA, 4'h3, 4'b0010, 4'b0000, 0, 0});
        vecs.push_back('{1, 1, 8'hBB, 8'hBB, 4'h4, 4'b0010, 4'b0000, 0, 0});
        vecs.push_back('{1, 0, 8'h00, 8'hBB, 4'h4, 4'b0000, 4'b0000, 0, 0});
        vecs.push_back('{0, 0, 8'h00, 8'hBB, 4'h4, 4'b0000, 4'b0000, 0, 0});
        // Header 0x0F -> main memory, address wraps 15 -> 0.
        vecs.push_back('{1, 0, 8'h00, 8'hBB, 4'h4, 4'b0000, 4'b0000, 0, 0});
        vecs.push_back('{1, 1, 8'h0F, 8'hBB, 4'h4, 4'b0000, 4'b0000, 0, 0});
        vecs.push_back('{1, 1, 8'h11, 8'h11, 4'hF, 4'b0000, 4'b0000, 1, 0});
        vecs.push_back('{1, 1, 8'h22, 8'h22, 4'h0, 4'b0000, 4'b0000, 1, 0});
        vecs.push_back('{0, 0, 8'h00, 8'h22, 4'h0, 4'b0000, 4'b0000, 0, 0});
        // Header 0x95 -> invalid id 9: discard, sticky err until next frame start.
        vecs.push_back('{1, 0, 8'h00, 8'h22, 4'h0, 4'b0000, 4'b0000, 0, 0});
        vecs.push_back('{1, 1, 8'h95, 8'h22, 4'h0, 4'b0000, 4'b0000, 0, 1});
        vecs.push_back('{1, 1, 8'h01, 8'h22, 4'h0, 4'b0000, 4'b0000, 0, 1});
        vecs.push_back('{1, 1, 8'h02, 8'h22, 4'h0, 4'b0000, 4'b0000, 0, 1});
        vecs.push_back('{1, 1, 8'h03, 8'h22, 4'h0, 4'b0000, 4'b0000, 0, 1});
        vecs.push_back('{0, 0, 8'h00, 8'h22, 4'h0, 4'b0000, 4'b0000, 0, 1});
        vecs.push_back('{1, 0, 8'h00, 8'h22, 4'h0, 4'b0000, 4'b0000, 0, 0});
        vecs.push_back('{0, 0, 8'h00, 8'h22, 4'h0, 4'b0000, 4'b0000, 0, 0});
        // Header 0x80 -> pulse_gen[3], four back-to-back bytes at 0..3.
        vecs.push_back('{1, 0, 8'h00, 8'h22, 4'h0, 4'b0000, 4'b0000, 0, 0});
        vecs.push_back('{1, 1, 8'h80, 8'h22, 4'h0, 4'b0000, 4'b0000, 0, 0});
        vecs.push_back('{1, 1, 8'hC0, 8'hC0, 4'h0, 4'b0000, 4'b1000, 0, 0});
        vecs.push_back('{1, 1, 8'hC1, 8'hC1, 4'h1, 4'b0000, 4'b1000, 0, 0});
        vecs.push_back('{1, 1, 8'hC2, 8'hC2, 4'h2, 4'b0000, 4'b1000, 0, 0});
        vecs.push_back('{1, 1, 8'hC3, 8'hC3, 4'h3, 4'b0000, 4'b1000, 0, 0});
        vecs.push_back('{0, 0, 8'h00, 8'hC3, 4'h3, 4'b0000, 4'b0000, 0, 0});

        apply(1'b0, 1'b0, 8'h00);
        apply(1'b0, 1'b0, 8'h00);
        check("reset", 8'h00, 4'h0, 4'b0000, 4'b0000, 0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i].f, vecs[i].v, vecs[i].d);
            check($sformatf("vec%0d", i), vecs[i].ed, vecs[i].ea, vecs[i].epps, vecs[i].epg,
                  vecs[i].em, vecs[i].ee);
        end

        // Frame drops in the same cycle as a data byte: ignored, FSM back to IDLE.
        apply(1'b1, 1'b0, 8'h00);
        apply(1'b1, 1'b1, 8'h50);
        apply(1'b0, 1'b1, 8'h77);
        check("drop_byte", 8'hC3, 4'h3, 4'b0000, 4'b0000, 0, 0);
        apply(1'b0, 1'b0, 8'h00);
        apply(1'b1, 1'b0, 8'h00);
        // If the FSM had stayed in DATA, 0x12 would strobe pulse_gen[0]; it must be a header.
        apply(1'b1, 1'b1, 8'h12);
        check("drop_new_hdr", 8'hC3, 4'h3, 4'b0000, 4'b0000, 0, 0);
        apply(1'b1, 1'b1, 8'h34);
        check("drop_new_data", 8'h34, 4'h2, 4'b0001, 4'b0000, 0, 0);
        apply(1'b0, 1'b0, 8'h00);

        // Reset mid-frame aborts; bytes while frame stays high produce nothing.
        apply(1'b1, 1'b0, 8'h00);
        apply(1'b1, 1'b1, 8'h62);
        apply(1'b1, 1'b1, 8'h55);
        check("pre_rst_data", 8'h55, 4'h2, 4'b0000, 4'b0010, 0, 0);
        rst = 1'b1;
        apply(1'b1, 1'b1, 8'h66);
        check("mid_rst", 8'h00, 4'h0, 4'b0000, 4'b0000, 0, 0);
        rst = 1'b0;
        apply(1'b1, 1'b1, 8'h77);
        check("post_rst_b0", 8'h00, 4'h0, 4'b0000, 4'b0000, 0, 0);
        apply(1'b1, 1'b1, 8'h88);
        check("post_rst_b1", 8'h00, 4'h0, 4'b0000, 4'b0000, 0, 0);
        apply(1'b1, 1'b1, 8'h01);
        check("post_rst_b2", 8'h00, 4'h0, 4'b0000, 4'b0000, 0, 0);
        apply(1'b0, 1'b0, 8'h00);
        apply(1'b1, 1'b0, 8'h00);
        apply(1'b1, 1'b1, 8'h03);
        check("new_frame_hdr", 8'h00, 4'h0, 4'b0000, 4'b0000, 0, 0);
        apply(1'b1, 1'b1, 8'h99);
        check("new_frame_data", 8'h99, 4'h3, 4'b0000, 4'b0000, 1, 0);
        apply(1'b1, 1'b0, 8'h00);
        check("strobe_one_cycle", 8'h99, 4'h3, 4'b0000, 4'b0000, 0, 0);
        apply(1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
